// File: rtl/pipe_delay_line_if.sv
// Bundle of the delay line's control, payload and status signals.
// Optional stall counter present when PIPE_DLY_STALL_CNT_EN is defined.
interface pipe_delay_line_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int OW = $clog2(DEPTH + 1);

  logic             stall;
  logic             flush;
  logic [DEPTH-1:0] kill;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    occupancy;
  logic             busy;
`ifdef PIPE_DLY_STALL_CNT_EN
  logic [31:0]      stall_cycles;

  modport master (
    output stall, flush, kill,
    output in_valid, in_data,
    input  out_valid, out_data,
    input  occupancy, busy,
    input  stall_cycles
  );

  modport slave (
    input  stall, flush, kill,
    input  in_valid, in_data,
    output out_valid, out_data,
    output occupancy, busy,
    output stall_cycles
  );
`else
  modport master (
    output stall, flush, kill,
    output in_valid, in_data,
    input  out_valid, out_data,
    input  occupancy, busy
  );

  modport slave (
    input  stall, flush, kill,
    input  in_valid, in_data,
    output out_valid, out_data,
    output occupancy, busy
  );
`endif
endinterface

// File: rtl/pipe_delay_line.sv
// DEPTH-stage payload+valid delay line with stall, flush, per-stage kill.
// PIPE_DLY_STALL_CNT_EN adds a saturating stall_cycles counter.
module pipe_delay_line #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  pipe_delay_line_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);

  logic             v_q [DEPTH];
  logic [WIDTH-1:0] d_q [DEPTH];
  logic             v_d [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic [OW-1:0]    killed;
  logic             accepted;
  logic             leaving;

  // next stage contents: flush > stall(hold+kill) > shift(with kill)
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_d[k] = 1'b0;
        d_d[k] = RESET_VAL;
      end
    end else if (bus.stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.kill[k]) begin
          v_d[k] = 1'b0;
          d_d[k] = RESET_VAL;
        end
      end
    end else begin
      v_d[0] = bus.in_valid;
      d_d[0] = bus.in_valid ? bus.in_data : RESET_VAL;
      for (int k = 1; k < DEPTH; k++) begin
        if (bus.kill[k-1]) begin
          v_d[k] = 1'b0;
          d_d[k] = RESET_VAL;
        end else begin
          v_d[k] = v_q[k-1];
          d_d[k] = d_q[k-1];
        end
      end
    end
  end

  // incremental occupancy: add accepted, drop leaving and killed
  always_comb begin
    killed = '0;
    for (int k = 0; k < DEPTH; k++) begin
      killed = killed + OW'(bus.kill[k] & v_q[k]);
    end
    accepted = !bus.stall && bus.in_valid;
    leaving  = !bus.stall && v_q[DEPTH-1]
               && !bus.kill[DEPTH-1];
    if (bus.flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OW'(accepted)
              - OW'(leaving) - killed;
    end
  end

  // stage and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= RESET_VAL;
      end
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

`ifdef PIPE_DLY_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // saturating count of stalled edges; flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus.stall && !bus.flush
                 && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`endif

  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.occupancy = occ_q;
  assign bus.busy      = (occ_q != '0);
endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboard bench for pipe_delay_line at DEPTH 1..4 sharing one stimulus.
// Reference model tracks tokens by stage position, not by stage registers.
module tb_pipe_delay_line;
  localparam logic [7:0] RV = 8'h5A;

  typedef struct {
    int         pos;
    logic [7:0] d;
  } tok_t;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    int          occ;
    logic [31:0] sc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] kill = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int depth,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s depth=%0d got=%0h expected=%0h",
                  name, depth, act, exp);
  endtask

  for (genvar g = 0; g < 4; g++) begin : gen_d
    localparam int D = g + 1;

    pipe_delay_line_if #(.WIDTH(8), .DEPTH(D)) bus ();

    pipe_delay_line #(
      .WIDTH(8), .DEPTH(D), .RESET_VAL(RV)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.stall    = stall;
    assign bus.flush    = flush;
    assign bus.kill     = kill[D-1:0];
    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;

    tok_t        toks[$];
    tok_t        nq[$];
    exp_t        expq[$];
    logic [31:0] sc = '0;

    always @(posedge clk) begin
      exp_t e;
      tok_t t;
      if (rst) sc = '0;
      else if (stall && !flush && sc != 32'hFFFF_FFFF) sc++;
      if (rst || flush) begin
        toks = {};
      end else begin
        nq = {};
        foreach (toks[i]) begin
          if (!kill[toks[i].pos]) begin
            t = toks[i];
            if (!stall) t.pos++;
            if (t.pos < D) nq.push_back(t);
          end
        end
        if (!stall && in_valid) begin
          t.pos = 0;
          t.d = in_data;
          nq.push_back(t);
        end
        toks = nq;
      end
      e.v = 1'b0;
      e.d = RV;
      foreach (toks[i]) begin
        if (toks[i].pos == D - 1) begin
          e.v = 1'b1;
          e.d = toks[i].d;
        end
      end
      e.occ = toks.size();
      e.sc = sc;
      expq.push_back(e);
    end

    always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 2)
        chk("queue_depth", D, expq.size(), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_valid", D, 32'(bus.out_valid), 32'(e.v));
        chk("out_data", D, 32'(bus.out_data), 32'(e.d));
        chk("occupancy", D, 32'(bus.occupancy), e.occ);
        chk("busy", D, 32'(bus.busy), 32'(e.occ != 0));
`ifdef PIPE_DLY_STALL_CNT_EN
        chk("stall_cycles", D, bus.stall_cycles, e.sc);
`endif
      end
    end
  end

  task automatic drive(input logic r, input logic s,
                       input logic f, input logic [3:0] k,
                       input logic iv, input logic [7:0] dt);
    rst      = r;
    stall    = s;
    flush    = f;
    kill     = k;
    in_valid = iv;
    in_data  = dt;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    drive(1, 0, 0, 4'h0, 0, 8'h00);
    drive(1, 0, 0, 4'h0, 0, 8'h00);
    // fill with 11,22,33 then idle
    drive(0, 0, 0, 4'h0, 1, 8'h11);
    drive(0, 0, 0, 4'h0, 1, 8'h22);
    drive(0, 0, 0, 4'h0, 1, 8'h33);
    repeat (4) drive(0, 0, 0, 4'h0, 0, 8'h00);
    // accept AA then stall 3 cycles offering BB
    drive(0, 0, 0, 4'h0, 1, 8'hAA);
    repeat (3) drive(0, 1, 0, 4'h0, 1, 8'hBB);
    repeat (4) drive(0, 0, 0, 4'h0, 0, 8'h00);
    // fill then flush with input offered
    drive(0, 0, 0, 4'h0, 1, 8'h01);
    drive(0, 0, 0, 4'h0, 1, 8'h02);
    drive(0, 0, 0, 4'h0, 1, 8'h03);
    drive(0, 0, 0, 4'h0, 1, 8'h04);
    drive(0, 1, 1, 4'h0, 1, 8'h44);
    repeat (2) drive(0, 0, 0, 4'h0, 0, 8'h00);
    // fill then kill stage 1 while shifting
    drive(0, 0, 0, 4'h0, 1, 8'hA0);
    drive(0, 0, 0, 4'h0, 1, 8'hB0);
    drive(0, 0, 0, 4'h0, 1, 8'hC0);
    drive(0, 0, 0, 4'h2, 1, 8'hD0);
    repeat (4) drive(0, 0, 0, 4'h0, 0, 8'h00);
    // full, then stall together with kill of stage 1
    repeat (4) drive(0, 0, 0, 4'h0, 1, 8'h60);
    drive(0, 1, 0, 4'h2, 1, 8'h61);
    repeat (5) drive(0, 0, 0, 4'h0, 0, 8'h00);
    // reset mid-stream on a full pipe, then restart
    repeat (4) drive(0, 0, 0, 4'h0, 1, 8'h70);
    drive(1, 0, 0, 4'h0, 1, 8'h71);
    drive(0, 0, 0, 4'h0, 1, 8'h72);
    repeat (5) drive(0, 0, 0, 4'h0, 0, 8'h00);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] k;
      k = '0;
      for (int b = 0; b < 4; b++)
        k[b] = ($urandom_range(99) < 8);
      drive($urandom_range(99) < 2,
            $urandom_range(99) < 25,
            $urandom_range(99) < 4,
            k,
            $urandom_range(99) < 75,
            8'($urandom));
    end
    repeat (6) drive(0, 0, 0, 4'h0, 0, 8'h00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
